ps2_rx: RTL and testbench



---
 rtl/ps2_rx.sv | 182 ++++++++++++++++++
 tb/tb_ps2_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// Filtered, frame-checked PS/2 keyboard receiver feeding the Tron core.
// Define PS2_DIRECTION_DECODE_EN to also decode the player direction registers.
module ps2_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keyboardCLK,
    input  logic       keyboardData,
    output logic [7:0] code,
    output logic       codeValid,
    output logic       breakCode,
    output logic       extended,
    output logic       frameError,
    output logic [4:0] direction1,
    output logic [4:0] direction2
);
    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]    FILT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
    state_t state, stateNext;

    logic [1:0]    clkSync, dataSync;
    logic [3:0]    filtCnt;
    logic          clkFilt, clkFiltPrev;
    logic          fallEdge, dataBit;
    logic [3:0]    bitCnt;
    logic [10:0]   frame;
    logic [TW-1:0] toCnt;
    logic          pendBreak, pendExt;
    logic          timeout, frameGood;
    logic [7:0]    frameData;

    // Filtered level only follows the synchronized clock after a stable run.
    always_ff @(posedge clk) begin
        if (reset) begin
            clkSync     <= 2'b11;
            dataSync    <= 2'b11;
            filtCnt     <= '0;
            clkFilt     <= 1'b1;
            clkFiltPrev <= 1'b1;
        end else begin
            clkSync     <= {clkSync[0], keyboardCLK};
            dataSync    <= {dataSync[0], keyboardData};
            clkFiltPrev <= clkFilt;
            if (clkSync[1] == clkFilt) begin
                filtCnt <= '0;
            end else if (filtCnt == FILT_LAST) begin
                clkFilt <= clkSync[1];
                filtCnt <= '0;
            end else begin
                filtCnt <= filtCnt + 4'd1;
            end
        end
    end

    assign fallEdge  = clkFiltPrev & ~clkFilt;
    assign dataBit   = dataSync[1];
    assign frameData = frame[8:1];
    assign frameGood = ~frame[0] & frame[10] & (^frame[9:1]);

    always_comb begin
        stateNext = state;
        timeout   = 1'b0;
        case (state)
            IDLE:  if (fallEdge && !dataBit) stateNext = RECV;
            RECV: begin
                if (fallEdge) begin
                    if (bitCnt == 4'd10) stateNext = CHECK;
                end else if (toCnt == TO_LIMIT) begin
                    timeout   = 1'b1;
                    stateNext = IDLE;
                end
            end
            CHECK: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bitCnt     <= '0;
            frame      <= '0;
            toCnt      <= '0;
            pendBreak  <= 1'b0;
            pendExt    <= 1'b0;
            code       <= 8'h00;
            codeValid  <= 1'b0;
            breakCode  <= 1'b0;
            extended   <= 1'b0;
            frameError <= 1'b0;
        end else begin
            state      <= stateNext;
            codeValid  <= 1'b0;
            frameError <= 1'b0;
            case (state)
                IDLE: begin
                    toCnt <= '0;
                    if (fallEdge && !dataBit) begin
                        frame[0] <= 1'b0;
                        bitCnt   <= 4'd1;
                    end
                end
                RECV: begin
                    if (fallEdge) begin
                        frame[bitCnt] <= dataBit;
                        bitCnt        <= bitCnt + 4'd1;
                        toCnt         <= '0;
                    end else if (timeout) begin
                        frameError <= 1'b1;
                        pendBreak  <= 1'b0;
                        pendExt    <= 1'b0;
                    end else begin
                        toCnt <= toCnt + TW'(1);
                    end
                end
                CHECK: begin
                    if (!frameGood) begin
                        frameError <= 1'b1;
                        pendBreak  <= 1'b0;
                        pendExt    <= 1'b0;
                    end else if (frameData == 8'hF0) begin
                        pendBreak <= 1'b1;
                    end else if (frameData == 8'hE0) begin
                        pendExt <= 1'b1;
                    end else begin
                        code      <= frameData;
                        codeValid <= 1'b1;
                        breakCode <= pendBreak;
                        extended  <= pendExt;
                        pendBreak <= 1'b0;
                        pendExt   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PS2_DIRECTION_DECODE_EN
    // A snake may not turn straight back onto itself.
    function automatic logic isOpposite(input logic [4:0] a, input logic [4:0] b);
        return (a == 5'b00010 && b == 5'b01000) || (a == 5'b01000 && b == 5'b00010) ||
               (a == 5'b00100 && b == 5'b10000) || (a == 5'b10000 && b == 5'b00100);
    endfunction

    logic [4:0] req1, req2;

    always_comb begin
        req1 = '0;
        req2 = '0;
        case (code)
            8'h1D: req1 = 5'b00010;
            8'h1C: req1 = 5'b00100;
            8'h1B: req1 = 5'b01000;
            8'h23: req1 = 5'b10000;
            8'h43: req2 = 5'b00010;
            8'h3B: req2 = 5'b00100;
            8'h42: req2 = 5'b01000;
            8'h4B: req2 = 5'b10000;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            direction1 <= 5'b10000;
            direction2 <= 5'b10000;
        end else if (codeValid && !breakCode && !extended) begin
            if (req1 != 5'b0 && !isOpposite(req1, direction1)) direction1 <= req1;
            if (req2 != 5'b0 && !isOpposite(req2, direction2)) direction2 <= req2;
        end
    end
`else
    assign direction1 = 5'b00000;
    assign direction2 = 5'b00000;
`endif
endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: table of frames plus timeout, stray-edge and reset sequences.
module tb_ps2_rx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       keyboardCLK = 1'b1;
    logic       keyboardData = 1'b1;
    logic [7:0] code;
    logic       codeValid, breakCode, extended, frameError;
    logic [4:0] direction1, direction2;

    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT_CYCLES = 50000;

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .reset(reset), .keyboardCLK(keyboardCLK), .keyboardData(keyboardData),
        .code(code), .codeValid(codeValid), .breakCode(breakCode), .extended(extended),
        .frameError(frameError), .direction1(direction1), .direction2(direction2)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    int cvCount = 0, feCount = 0, cvCyc = 0;
    logic cvPrev = 1'b0, fePrev = 1'b0, wideSeen = 1'b0;
    int errors = 0, checks = 0;
    int lastFall = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (codeValid) begin
            cvCount++;
            cvCyc = cyc;
        end
        if (frameError) feCount++;
        if ((codeValid && cvPrev) || (frameError && fePrev)) wideSeen = 1'b1;
        cvPrev = codeValid;
        fePrev = frameError;
    end

    typedef struct {
        logic [7:0] data;
        logic       badPar;
        int         expValid;
        int         expErr;
        logic [7:0] expCode;
        logic       expBrk;
        logic       expExt;
        logic [4:0] expDir1;
        logic [4:0] expDir2;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] d, input logic bp, input int v, input int e,
                                input logic [7:0] c, input logic b, input logic x,
                                input logic [4:0] d1, input logic [4:0] d2);
        vec_t r;
        r.data = d; r.badPar = bp; r.expValid = v; r.expErr = e; r.expCode = c;
        r.expBrk = b; r.expExt = x; r.expDir1 = d1; r.expDir2 = d2;
        return r;
    endfunction

    function automatic logic [4:0] dx(input logic [4:0] v);
`ifdef PS2_DIRECTION_DECODE_EN
        return v;
`else
        return 5'b00000;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendBit(input logic b);
        keyboardData = b;
        tick(10);
        keyboardCLK = 1'b0;
        lastFall = cyc;
        tick(20);
        keyboardCLK = 1'b1;
        tick(10);
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic bad);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(d[i]);
        sendBit(~(^d) ^ bad);
        sendBit(1'b1);
    endtask

    task automatic chkOutputs(input string tag, input logic [7:0] c, input logic b, input logic x,
                              input logic [4:0] d1, input logic [4:0] d2);
        chk({tag, "_code"}, int'(code), int'(c));
        chk({tag, "_break"}, int'(breakCode), int'(b));
        chk({tag, "_ext"}, int'(extended), int'(x));
        chk({tag, "_dir1"}, int'(direction1), int'(dx(d1)));
        chk({tag, "_dir2"}, int'(direction2), int'(dx(d2)));
    endtask

    vec_t vecs[12];

    initial begin
        int cv0, fe0, t0, stopCyc;

        vecs[0]  = mk(8'h1D, 0, 1, 0, 8'h1D, 0, 0, 5'b00010, 5'b10000);
        vecs[1]  = mk(8'hF0, 0, 0, 0, 8'h1D, 0, 0, 5'b00010, 5'b10000);
        vecs[2]  = mk(8'h1D, 0, 1, 0, 8'h1D, 1, 0, 5'b00010, 5'b10000);
        vecs[3]  = mk(8'hE0, 0, 0, 0, 8'h1D, 1, 0, 5'b00010, 5'b10000);
        vecs[4]  = mk(8'h4B, 0, 1, 0, 8'h4B, 0, 1, 5'b00010, 5'b10000);
        vecs[5]  = mk(8'h23, 1, 0, 1, 8'h4B, 0, 1, 5'b00010, 5'b10000);
        vecs[6]  = mk(8'h23, 0, 1, 0, 8'h23, 0, 0, 5'b10000, 5'b10000);
        vecs[7]  = mk(8'h1C, 0, 1, 0, 8'h1C, 0, 0, 5'b10000, 5'b10000);
        vecs[8]  = mk(8'h1D, 0, 1, 0, 8'h1D, 0, 0, 5'b00010, 5'b10000);
        vecs[9]  = mk(8'h43, 0, 1, 0, 8'h43, 0, 0, 5'b00010, 5'b00010);
        vecs[10] = mk(8'h42, 0, 1, 0, 8'h42, 0, 0, 5'b00010, 5'b00010);
        vecs[11] = mk(8'h3B, 0, 1, 0, 8'h3B, 0, 0, 5'b00010, 5'b00100);

        tick(5);
        chk("rst_codeValid", int'(codeValid), 0);
        chk("rst_frameError", int'(frameError), 0);
        chkOutputs("rst", 8'h00, 0, 0, 5'b10000, 5'b10000);
        reset = 1'b0;
        tick(20);

        for (int i = 0; i < 12; i++) begin
            cv0 = cvCount;
            fe0 = feCount;
            sendFrame(vecs[i].data, vecs[i].badPar);
            stopCyc = lastFall;
            tick(20);
            chk($sformatf("v%0d_validPulses", i), cvCount - cv0, vecs[i].expValid);
            chk($sformatf("v%0d_errPulses", i), feCount - fe0, vecs[i].expErr);
            chkOutputs($sformatf("v%0d", i), vecs[i].expCode, vecs[i].expBrk, vecs[i].expExt,
                       vecs[i].expDir1, vecs[i].expDir2);
            // 2 sync flops + FILTER_LEN stable samples, then detect cycle + 2
            if (i == 0) chk("latency", cvCyc - stopCyc, FILTER_LEN + 4);
        end

        // Timeout mid-frame, with a pending break prefix that must be dropped.
        sendFrame(8'hF0, 0);
        tick(20);
        cv0 = cvCount;
        fe0 = feCount;
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'b1);
        t0 = lastFall;
        while (feCount == fe0 && (cyc - t0) < TIMEOUT_CYCLES + 100) tick(1);
        chk("timeout_fired", feCount - fe0, 1);
        chk("timeout_window", int'((cyc - t0) >= TIMEOUT_CYCLES && (cyc - t0) <= TIMEOUT_CYCLES + 30), 1);
        chk("timeout_noValid", cvCount - cv0, 0);
        sendFrame(8'h1C, 0);
        tick(20);
        chk("afterTimeout_valid", cvCount - cv0, 1);
        chkOutputs("afterTimeout", 8'h1C, 0, 0, 5'b00100, 5'b00100);

        // Lone falling edge with data high must not start a frame.
        cv0 = cvCount;
        fe0 = feCount;
        sendBit(1'b1);
        sendFrame(8'h1B, 0);
        tick(20);
        chk("strayEdge_valid", cvCount - cv0, 1);
        chk("strayEdge_err", feCount - fe0, 0);
        chkOutputs("strayEdge", 8'h1B, 0, 0, 5'b01000, 5'b00100);

        // Reset in the middle of a frame after a break prefix.
        sendFrame(8'hF0, 0);
        tick(20);
        cv0 = cvCount;
        fe0 = feCount;
        sendBit(1'b0);
        for (int i = 0; i < 3; i++) sendBit(1'b1);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(100);
        chk("midReset_noValid", cvCount - cv0, 0);
        chk("midReset_noErr", feCount - fe0, 0);
        chkOutputs("midReset", 8'h00, 0, 0, 5'b10000, 5'b10000);
        sendFrame(8'h1D, 0);
        tick(20);
        chk("postReset_valid", cvCount - cv0, 1);
        chkOutputs("postReset", 8'h1D, 0, 0, 5'b00010, 5'b10000);

        chk("strobeWidth", int'(wideSeen), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
